md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 82 ++++++++
 tb/tb_md_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide unit with HI/LO registers and stall request
module md_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  EOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        DIsMd,
    output logic        Busy,
    output logic        Start,
    output logic        StallReq,
    output logic [31:0] MdOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MFHI = 4'd7, OP_MFLO = 4'd8;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [63:0] res_q, res_d, prod;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic is_mul, is_div, sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, q_u, r_u, q, r;
    always_comb begin
        is_mul = EOp == OP_MULT || EOp == OP_MULTU;
        is_div = EOp == OP_DIV || EOp == OP_DIVU;
        sgn = EOp == OP_MULT || EOp == OP_DIV;
        a_neg = sgn & A[31];
        b_neg = sgn & B[31];
        prod = {{32{a_neg}}, A} * {{32{b_neg}}, B};
        // Signed division via magnitudes keeps truncation toward zero well defined
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
        b_div = b_mag == 32'd0 ? 32'd1 : b_mag;
        q_u = a_mag / b_div;
        r_u = a_mag % b_div;
        q = (a_neg ^ b_neg) ? -q_u : q_u;
        r = a_neg ? -r_u : r_u;
        Busy = state_q == RUN;
        Start = !Busy && (is_mul || is_div);
        StallReq = DIsMd & (Busy | Start);
        MdOut = EOp == OP_MFHI ? hi_q : EOp == OP_MFLO ? lo_q : 32'd0;
        state_d = state_q;
        cnt_d = cnt_q;
        res_d = res_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (Start) begin
            state_d = RUN;
            cnt_d = is_mul ? 4'd5 : 4'd10;
            // Divide by zero buffers the current HI/LO so completion rewrites them unchanged
            res_d = is_mul ? prod : (B == 32'd0 ? {hi_q, lo_q} : {r, q});
        end else if (!Busy) begin
            hi_d = EOp == OP_MTHI ? A : hi_q;
            lo_d = EOp == OP_MTLO ? A : lo_q;
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                {hi_d, lo_d} = res_q;
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
            res_q <= 64'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign HI = hi_q;
    assign LO = lo_q;
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: vector table, directed corner sequences and random run against a cycle-count model
module tb_md_ctrl;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;
    logic Clk = 1'b0, Reset = 1'b1, DIsMd = 1'b0;
    logic [3:0] EOp = 4'd0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic Busy, Start, StallReq;
    logic [31:0] MdOut, HI, LO;
    int n_vec = 0, n_err = 0;
    md_ctrl dut (
        .Clk(Clk), .Reset(Reset), .EOp(EOp), .A(A), .B(B), .DIsMd(DIsMd),
        .Busy(Busy), .Start(Start), .StallReq(StallReq), .MdOut(MdOut), .HI(HI), .LO(LO)
    );
    always #5 Clk = ~Clk;
    typedef struct {
        logic [3:0] op; logic [31:0] a, b; logic d;
        logic busy, start, stall; logic [31:0] md, hi, lo;
    } vec_t;
    vec_t tbl[12];
    int m_left = 0;
    bit m_wr = 1'b0;
    logic [63:0] m_res = 64'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == MULT) return sa * sb;
        if (op == MULTU) return ua * ub;
        if (b == 32'd0) return 64'd0;
        if (op == DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction
    task automatic step(input logic rst, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic d);
        bit e_busy, e_start;
        Reset = rst; EOp = op; A = a; B = b; DIsMd = d;
        #1;
        e_busy = m_left > 0;
        e_start = !e_busy && op >= MULT && op <= DIVU;
        chk("busy", 32'(Busy), 32'(e_busy));
        chk("start", 32'(Start), 32'(e_start));
        chk("stall", 32'(StallReq), 32'(d & (e_busy | e_start)));
        chk("mdout", MdOut, op == MFHI ? m_hi : op == MFLO ? m_lo : 32'd0);
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
        if (rst) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (e_busy) begin
            m_left--;
            if (m_left == 0 && m_wr) {m_hi, m_lo} = m_res;
        end else if (e_start) begin
            m_left = op <= MULTU ? 5 : 10;
            m_res = calc(op, a, b);
            m_wr = !(op >= DIV && b == 32'd0);
        end else if (op == MTHI) m_hi = a;
        else if (op == MTLO) m_lo = a;
        @(negedge Clk);
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction
    initial begin
        tbl[0]  = '{NONE,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{MTHI,  32'h12345678, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{MFHI,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 32'h0};
        tbl[3]  = '{MTLO,  32'hCAFEBABE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h12345678, 32'h0};
        tbl[4]  = '{MFLO,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE};
        tbl[5]  = '{MULT,  32'hFFFFFFFE, 32'h3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h12345678, 32'hCAFEBABE};
        tbl[6]  = '{MFHI,  32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h12345678, 32'hCAFEBABE};
        tbl[7]  = '{MTLO,  32'h0BADF00D, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'hCAFEBABE};
        tbl[8]  = '{MFLO,  32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE};
        tbl[9]  = '{MTHI,  32'h55555555, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'hCAFEBABE};
        tbl[10] = '{MULTU, 32'h7, 32'h7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'hCAFEBABE};
        tbl[11] = '{MFLO,  32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA};
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            EOp = tbl[i].op; A = tbl[i].a; B = tbl[i].b; DIsMd = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d busy", i), 32'(Busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d start", i), 32'(Start), 32'(tbl[i].start));
            chk($sformatf("tbl%0d stall", i), 32'(StallReq), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d mdout", i), MdOut, tbl[i].md);
            chk($sformatf("tbl%0d hi", i), HI, tbl[i].hi);
            chk($sformatf("tbl%0d lo", i), LO, tbl[i].lo);
            @(negedge Clk);
        end
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
        step(1'b0, DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("div busy", 32'(Busy), 32'd1);
            step(1'b0, NONE, 32'd0, 32'd0, 1'b1);
        end
        #1;
        chk("div done busy", 32'(Busy), 32'd0);
        chk("div stall drop", 32'(StallReq), 32'd0);
        chk("div lo", LO, 32'hFFFFFFFD);
        chk("div hi", HI, 32'hFFFFFFFF);
        step(1'b0, MTHI, 32'hA5A5A5A5, 32'd0, 1'b0);
        step(1'b0, DIVU, 32'd7, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("divu0 busy", 32'(Busy), 32'd1);
            step(1'b0, NONE, 32'd0, 32'd0, 1'b0);
        end
        #1;
        chk("divu0 busy end", 32'(Busy), 32'd0);
        chk("divu0 hi", HI, 32'hA5A5A5A5);
        chk("divu0 lo", LO, 32'hFFFFFFFD);
        step(1'b0, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        step(1'b0, DIV, 32'd100, 32'd3, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, MTHI, 32'd9, 32'd0, 1'b0);
        #1;
        chk("multu hi", HI, 32'hFFFFFFFE);
        chk("multu lo", LO, 32'h00000001);
        step(1'b0, MULTU, 32'd5, 32'd6, 1'b0);
        step(1'b0, NONE, 32'd0, 32'd0, 1'b0);
        step(1'b0, NONE, 32'd0, 32'd0, 1'b0);
        step(1'b1, NONE, 32'd0, 32'd0, 1'b0);
        #1;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort hi", HI, 32'd0);
        chk("abort lo", LO, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, NONE, 32'd0, 32'd0, 1'b0);
        #1;
        chk("abort later lo", LO, 32'd0);
        step(1'b0, MTHI, 32'd1, 32'd0, 1'b0);
        step(1'b0, MULT, 32'd2, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, NONE, 32'd0, 32'd0, 1'b0);
        step(1'b1, NONE, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rst vs done hi", HI, 32'd0);
        chk("rst vs done lo", LO, 32'd0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 63) == 0, 4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
